// File: rtl/logic_result_uart_tx.sv
// logic_result_uart_tx: buffers selector result bytes in a small FIFO and sends each
// as a serial frame (start, 8 data bits LSB first, optional even parity, stop).
module logic_result_uart_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam int CW  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH_CNT = AW1'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        r_state;
  state_t        w_stateNext;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;
  logic [CW-1:0] r_bitCnt;
  logic [2:0]    r_bitIdx;
  logic [7:0]    r_shift;
  logic [7:0]    w_shiftNext;
  logic          r_parity;
  logic          r_tx;
  logic          w_txNext;
  logic          w_bitLast;
  logic          w_stopLast;
  logic          w_pop;
  logic          w_push;

  assign w_bitLast  = (r_bitCnt == BIT_LAST);
  assign w_stopLast = (r_state == STOP) && w_bitLast;
  assign w_pop      = ((r_state == IDLE) || w_stopLast) && ena && (r_count != '0);
  assign in_ready   = !rst && (r_count < DEPTH_CNT);
  assign w_push     = in_valid && in_ready;

  assign tx_out     = r_tx;
  assign tx_busy    = (r_state != IDLE);
  assign frame_done = w_stopLast;
  assign fifo_count = r_count;

  // FIFO storage carries no reset; only the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_pop) w_stateNext = START;
      START:   if (w_bitLast) w_stateNext = DATA;
      DATA:    if (w_bitLast && (r_bitIdx == 3'd7))
                 w_stateNext = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY:  if (w_bitLast) w_stateNext = STOP;
      STOP:    if (w_bitLast) w_stateNext = w_pop ? START : IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // tx_out is registered, so it is driven from the state being entered next cycle.
  always_comb begin
    w_shiftNext = r_shift;
    if (w_pop) w_shiftNext = r_mem[r_rdPtr];
    else if ((r_state == DATA) && w_bitLast) w_shiftNext = {1'b0, r_shift[7:1]};
    w_txNext = 1'b1;
    case (w_stateNext)
      START:   w_txNext = 1'b0;
      DATA:    w_txNext = w_shiftNext[0];
      PARITY:  w_txNext = r_parity;
      default: w_txNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bitCnt <= '0;
      r_bitIdx <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
      r_tx     <= 1'b1;
    end else begin
      r_shift <= w_shiftNext;
      r_tx    <= w_txNext;
      if (w_pop) begin
        r_parity <= ^r_mem[r_rdPtr];
        r_bitIdx <= '0;
      end else if ((r_state == DATA) && w_bitLast) begin
        r_bitIdx <= r_bitIdx + 3'd1;
      end
      if ((r_state == IDLE) || w_bitLast) r_bitCnt <= '0;
      else                                r_bitCnt <= r_bitCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_logic_result_uart_tx.sv
// tb_logic_result_uart_tx: frame-level reference model checked every cycle, a table
// of byte/parity vectors, and directed sequences for the multi-cycle corner cases.
module tb_logic_result_uart_tx;
  localparam int CPB        = 4;
  localparam int DEPTH      = 4;
  localparam int FRAME_BITS = 11;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;

  typedef struct {
    logic [7:0] data;
    logic       parity;
  } vec_t;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       ena      = 1'b0;
  logic [7:0] inData   = 8'h00;
  logic       inValid  = 1'b0;
  logic       inReady, txOut, txBusy, frameDone;
  logic [2:0] fifoCount;
  logic       ena2     = 1'b1;
  logic [7:0] inData2  = 8'h00;
  logic       inValid2 = 1'b0;
  logic       inReady2, txOut2, txBusy2, frameDone2;
  logic [2:0] fifoCount2;

  int errors = 0;
  int checks = 0;

  logic [7:0]            mQ[$];
  logic                  mBusy = 1'b0;
  int                    mPos  = 0;
  logic [FRAME_BITS-1:0] mBits = '1;
  logic [7:0]            mByte;
  logic                  mPush, mLast, mPopNow;

  always #5 clk = ~clk;

  logic_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .ena(ena), .in_data(inData), .in_valid(inValid),
    .in_ready(inReady), .tx_out(txOut), .tx_busy(txBusy), .frame_done(frameDone),
    .fifo_count(fifoCount)
  );

  logic_result_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .PARITY_EN(0)) dutNoPar (
    .clk(clk), .rst(rst), .ena(ena2), .in_data(inData2), .in_valid(inValid2),
    .in_ready(inReady2), .tx_out(txOut2), .tx_busy(txBusy2), .frame_done(frameDone2),
    .fifo_count(fifoCount2)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic e,
                               input logic r);
    @(posedge clk);
    #1;
    inValid = v;
    inData  = d;
    ena     = e;
    rst     = r;
    @(negedge clk);
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((txBusy || (fifoCount != 3'd0)) && (n < 500)) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      n++;
    end
    checkOutput("idleTimeout", {31'd0, (txBusy || (fifoCount != 3'd0))}, 32'd0);
  endtask

  // Reference: a queue of bytes and a whole frame laid out as a bit vector in time.
  always @(posedge clk) begin
    if (rst) begin
      mQ.delete();
      mBusy = 1'b0;
      mPos  = 0;
    end else begin
      mPush   = inValid && (mQ.size() < DEPTH);
      mLast   = mBusy && (mPos == FRAME_CYC - 1);
      mPopNow = (!mBusy || mLast) && ena && (mQ.size() > 0);
      if (mPopNow) begin
        mByte = mQ.pop_front();
        mBits = {1'b1, ^mByte, mByte, 1'b0};
        mBusy = 1'b1;
        mPos  = 0;
      end else if (mLast) begin
        mBusy = 1'b0;
      end else if (mBusy) begin
        mPos++;
      end
      if (mPush) mQ.push_back(inData);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rstTx", txOut, 1);
      checkOutput("rstBusy", txBusy, 0);
      checkOutput("rstDone", frameDone, 0);
      checkOutput("rstCount", fifoCount, 0);
      checkOutput("rstReady", inReady, 0);
    end else begin
      checkOutput("modelTx", txOut, mBusy ? mBits[mPos / CPB] : 1'b1);
      checkOutput("modelBusy", txBusy, mBusy);
      checkOutput("modelDone", frameDone, mBusy && (mPos == FRAME_CYC - 1));
      checkOutput("modelCount", fifoCount, mQ.size());
      checkOutput("modelReady", inReady, mQ.size() < DEPTH);
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t          vecs[7];
    logic [10:0]   rx;
    logic [10:0]   rxF[4];
    logic [7:0]    pat;
    logic          expTx;
    int            doneAt;
    int            doneCount;
    int            k;
    int            w;

    vecs[0] = '{8'hA5, 1'b0};
    vecs[1] = '{8'h07, 1'b1};
    vecs[2] = '{8'h00, 1'b0};
    vecs[3] = '{8'hFF, 1'b0};
    vecs[4] = '{8'h80, 1'b1};
    vecs[5] = '{8'h3C, 1'b0};
    vecs[6] = '{8'h5B, 1'b1};

    @(negedge clk);
    checkOutput("resetTx", txOut, 1);
    checkOutput("resetBusy", txBusy, 0);
    checkOutput("resetReady", inReady, 0);
    checkOutput("resetCount", fifoCount, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("releaseReady", inReady, 1);

    // Single 0xA5 frame with exact cycle positions
    pat = 8'hA5;
    for (int c = 0; c < 48; c++) begin
      applyStimulus(c == 0, 8'hA5, 1'b1, 1'b0);
      if (c < 2 || c > 45) expTx = 1'b1;
      else if (c < 6)      expTx = 1'b0;
      else if (c < 38)     expTx = pat[(c - 6) / 4];
      else if (c < 42)     expTx = 1'b0;
      else                 expTx = 1'b1;
      checkOutput("a5Tx", txOut, expTx);
      checkOutput("a5Done", frameDone, c == 45);
      checkOutput("a5Busy", txBusy, (c >= 2) && (c <= 45));
      if (c == 1) checkOutput("a5Count", fifoCount, 1);
    end

    for (int i = 0; i < 7; i++) begin
      waitIdle();
      rx = '0;
      doneAt = -1;
      for (int c = 0; c < 47; c++) begin
        applyStimulus(c == 0, vecs[i].data, 1'b1, 1'b0);
        if ((c >= 2) && (c < 46) && (((c - 2) % CPB) == 1)) rx[(c - 2) / CPB] = txOut;
        if (frameDone) doneAt = c;
      end
      checkOutput("vecStart", rx[0], 0);
      checkOutput("vecData", rx[8:1], vecs[i].data);
      checkOutput("vecParity", rx[9], vecs[i].parity);
      checkOutput("vecStop", rx[10], 1);
      checkOutput("vecDoneAt", doneAt, 45);
    end

    // Fill with ena low, then drain four frames back to back
    waitIdle();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 8'(c + 1), 1'b0, 1'b0);
      checkOutput("fullReady", inReady, c < 4);
      checkOutput("fullCount", fifoCount, c);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fullCount5", fifoCount, 4);
    checkOutput("fullReady5", inReady, 0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("popCycleReady", inReady, 0);
    doneCount = 0;
    for (int t = 0; t <= 4 * FRAME_CYC; t++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      if (t == 0) checkOutput("afterPopReady", inReady, 1);
      if (t < 4 * FRAME_CYC) begin
        k = t / FRAME_CYC;
        w = t % FRAME_CYC;
        checkOutput("b2bBusy", txBusy, 1);
        if (w == 0) checkOutput("b2bStart", txOut, 0);
        if ((w % CPB) == 1) rxF[k][w / CPB] = txOut;
      end else begin
        checkOutput("b2bIdle", txBusy, 0);
      end
      if (frameDone) doneCount++;
    end
    for (int f = 0; f < 4; f++) checkOutput("b2bData", rxF[f][8:1], f + 1);
    checkOutput("b2bDoneCount", doneCount, 4);

    // ena dropped during data bit 3 with a second byte waiting
    waitIdle();
    for (int c = 0; c < 67; c++) begin
      applyStimulus(c < 2, (c == 0) ? 8'h11 : 8'h22,
                    ((c >= 2) && (c < 20)) || (c >= 60), 1'b0);
      if (c == 46) begin
        checkOutput("enaDropDone", frameDone, 1);
        checkOutput("enaDropCount46", fifoCount, 1);
      end
      if ((c >= 47) && (c <= 60)) begin
        checkOutput("enaHoldTx", txOut, 1);
        checkOutput("enaHoldBusy", txBusy, 0);
        checkOutput("enaHoldCount", fifoCount, 1);
      end
      if (c == 61) begin
        checkOutput("enaResumeTx", txOut, 0);
        checkOutput("enaResumeBusy", txBusy, 1);
        checkOutput("enaResumeCount", fifoCount, 0);
      end
    end

    // Reset asserted during the parity bit with two bytes still queued
    waitIdle();
    doneCount = 0;
    for (int c = 0; c < 104; c++) begin
      applyStimulus(c < 3, 8'(8'h31 + c), c >= 3, (c == 41) || (c == 42));
      if (c == 41) begin
        checkOutput("midRstTx", txOut, 1);
        checkOutput("midRstCount", fifoCount, 0);
        checkOutput("midRstBusy", txBusy, 0);
        checkOutput("midRstReady", inReady, 0);
      end
      if (c >= 41) begin
        if (frameDone) doneCount++;
        checkOutput("postRstTx", txOut, 1);
        checkOutput("postRstBusy", txBusy, 0);
      end
    end
    checkOutput("postRstNoDone", doneCount, 0);

    for (int c = 0; c < 800; c++)
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom),
                    ($urandom_range(0, 9) != 0), 1'b0);
    waitIdle();

    // Parity disabled: 10-bit frame of 40 cycles
    pat = 8'h07;
    for (int c = 0; c < 44; c++) begin
      @(posedge clk);
      #1;
      inValid2 = (c == 0);
      inData2  = 8'h07;
      @(negedge clk);
      if (c < 2 || c > 41) expTx = 1'b1;
      else if (c < 6)      expTx = 1'b0;
      else if (c < 38)     expTx = pat[(c - 6) / 4];
      else                 expTx = 1'b1;
      checkOutput("noParTx", txOut2, expTx);
      checkOutput("noParBusy", txBusy2, (c >= 2) && (c <= 41));
      checkOutput("noParDone", frameDone2, c == 41);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
